// File: rtl/sr_ff_bank.sv
// sr_ff_bank: WIDTH independent clocked storage channels with run-time SR/JK/D/T mode,
// per-channel enable, configurable S=R=1 resolution and sticky violation flags.
// Optional feature macro: SR_VIOL_CNT_EN adds a saturating violation event counter (viol_cnt).
module sr_ff_bank #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       SR_PRIORITY = 0,
    parameter logic [WIDTH-1:0]  RESET_VAL   = '0,
    parameter int unsigned       CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] enable,
    input  logic             viol_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] notq,
    output logic [WIDTH-1:0] viol,
    output logic             viol_any
`ifdef SR_VIOL_CNT_EN
    ,
    output logic [CNT_W-1:0] viol_cnt
`endif
);

    typedef enum logic [1:0] {
        ModeSr = 2'b00,
        ModeJk = 2'b01,
        ModeD  = 2'b10,
        ModeT  = 2'b11
    } mode_e;

    // Reject illegal configurations at elaboration.
    if (WIDTH < 1 || WIDTH > 32 || CNT_W < 1) begin : g_param_check
        $error("sr_ff_bank: WIDTH must be 1..32 and CNT_W at least 1");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] viol_q, viol_d;
    logic             viol_any_q;
    logic [WIDTH-1:0] hit;

    // Next-state for each channel plus detection of enabled S=R=1 in SR mode.
    always_comb begin
        q_d    = q_q;
        viol_d = viol_clr ? '0 : viol_q;
        hit    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (enable[i]) begin
                unique case (mode_e'(mode))
                    ModeSr: begin
                        case ({s[i], r[i]})
                            2'b10: q_d[i] = 1'b1;
                            2'b01: q_d[i] = 1'b0;
                            2'b11: begin
                                hit[i] = 1'b1;
                                // Any priority code other than 1 or 2 resolves as hold.
                                if (SR_PRIORITY == 1) begin
                                    q_d[i] = 1'b1;
                                end else if (SR_PRIORITY == 2) begin
                                    q_d[i] = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                    ModeJk: begin
                        case ({s[i], r[i]})
                            2'b10: q_d[i] = 1'b1;
                            2'b01: q_d[i] = 1'b0;
                            2'b11: q_d[i] = ~q_q[i];
                            default: ;
                        endcase
                    end
                    ModeD: q_d[i] = s[i];
                    ModeT: begin
                        if (s[i]) begin
                            q_d[i] = ~q_q[i];
                        end
                    end
                    default: ;
                endcase
            end
        end
        // A fresh violation beats a simultaneous clear.
        viol_d = viol_d | hit;
    end

    // State registers; reset is asynchronous and overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= RESET_VAL;
            viol_q     <= '0;
            viol_any_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            viol_q     <= viol_d;
            viol_any_q <= |viol_d;
        end
    end

    assign q        = q_q;
    assign notq     = ~q_q;
    assign viol     = viol_q;
    assign viol_any = viol_any_q;

`ifdef SR_VIOL_CNT_EN
    localparam int unsigned     SumW   = CNT_W + 6;
    localparam logic [SumW-1:0] CntMax = {6'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
    logic [5:0]       hit_pop;
    logic [SumW-1:0]  cnt_sum;

    // Saturating add of this edge's violating-channel count; clear restarts from zero.
    always_comb begin
        hit_pop = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            hit_pop = hit_pop + 6'(hit[i]);
        end
        cnt_sum = (viol_clr ? '0 : SumW'(viol_cnt_q)) + SumW'(hit_pop);
        if (cnt_sum > CntMax) begin
            viol_cnt_d = '1;
        end else begin
            viol_cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    // Violation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_cnt_q <= '0;
        end else begin
            viol_cnt_q <= viol_cnt_d;
        end
    end

    assign viol_cnt = viol_cnt_q;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed self-checking bench for sr_ff_bank. Three instances share stimulus and differ only
// in SR_PRIORITY (0/1/2); the counter test is built only when SR_VIOL_CNT_EN is defined.
module tb_sr_ff_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [7:0] s, r, enable;
    logic       viol_clr;

    logic [7:0] q0, notq0, viol0;
    logic [7:0] q1, notq1, viol1;
    logic [7:0] q2, notq2, viol2;
    logic       viol_any0, viol_any1, viol_any2;
`ifdef SR_VIOL_CNT_EN
    logic [3:0] cnt0, cnt1, cnt2;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    sr_ff_bank #(.WIDTH(8), .SR_PRIORITY(0), .RESET_VAL(8'hA5), .CNT_W(4)) dut_p0 (
        .clk(clk), .rst(rst), .mode(mode), .s(s), .r(r), .enable(enable), .viol_clr(viol_clr),
        .q(q0), .notq(notq0), .viol(viol0), .viol_any(viol_any0)
`ifdef SR_VIOL_CNT_EN
        , .viol_cnt(cnt0)
`endif
    );

    sr_ff_bank #(.WIDTH(8), .SR_PRIORITY(1), .RESET_VAL(8'hA5), .CNT_W(4)) dut_p1 (
        .clk(clk), .rst(rst), .mode(mode), .s(s), .r(r), .enable(enable), .viol_clr(viol_clr),
        .q(q1), .notq(notq1), .viol(viol1), .viol_any(viol_any1)
`ifdef SR_VIOL_CNT_EN
        , .viol_cnt(cnt1)
`endif
    );

    sr_ff_bank #(.WIDTH(8), .SR_PRIORITY(2), .RESET_VAL(8'hA5), .CNT_W(4)) dut_p2 (
        .clk(clk), .rst(rst), .mode(mode), .s(s), .r(r), .enable(enable), .viol_clr(viol_clr),
        .q(q2), .notq(notq2), .viol(viol2), .viol_any(viol_any2)
`ifdef SR_VIOL_CNT_EN
        , .viol_cnt(cnt2)
`endif
    );

    // Advance one edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [7:0] sv, input logic [7:0] rv,
                         input logic [7:0] en, input logic clr);
        mode = m; s = sv; r = rv; enable = en; viol_clr = clr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
        #3;
        checks++; if (q0 !== 8'hA5) begin fails++; $display("FAIL reset_q got %h exp a5", q0); end
        checks++; if (notq0 !== 8'h5A) begin fails++; $display("FAIL reset_notq got %h exp 5a", notq0); end
        checks++; if (viol0 !== 8'h00 || viol_any0 !== 1'b0) begin
            fails++; $display("FAIL reset_viol got %h/%b exp 00/0", viol0, viol_any0);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (q0 !== 8'hA5) begin fails++; $display("FAIL reset_hold got %h exp a5", q0); end
    endtask

    task automatic test_sr();
        drive(2'b00, 8'h0F, 8'hF0, 8'hFF, 1'b0); tick();
        checks++; if (q0 !== 8'h0F || notq0 !== 8'hF0) begin
            fails++; $display("FAIL sr_set_clr got %h/%h exp 0f/f0", q0, notq0);
        end
        drive(2'b00, 8'h00, 8'h00, 8'hFF, 1'b0); tick();
        checks++; if (q0 !== 8'h0F) begin fails++; $display("FAIL sr_hold got %h exp 0f", q0); end
        // Forbidden input with q[0]=1.
        drive(2'b00, 8'h01, 8'h01, 8'hFF, 1'b0); tick();
        checks++; if (q0 !== 8'h0F) begin fails++; $display("FAIL sr_forbid_p0_a got %h exp 0f", q0); end
        checks++; if (q1 !== 8'h0F) begin fails++; $display("FAIL sr_forbid_p1_a got %h exp 0f", q1); end
        checks++; if (q2 !== 8'h0E) begin fails++; $display("FAIL sr_forbid_p2_a got %h exp 0e", q2); end
        checks++; if (viol0 !== 8'h01 || viol_any0 !== 1'b1) begin
            fails++; $display("FAIL sr_viol got %h/%b exp 01/1", viol0, viol_any0);
        end
        drive(2'b00, 8'h00, 8'h01, 8'hFF, 1'b0); tick();
        checks++; if (q0 !== 8'h0E || viol0 !== 8'h01) begin
            fails++; $display("FAIL sr_sticky got %h/%h exp 0e/01", q0, viol0);
        end
        // Forbidden input with q[0]=0 separates hold from set-wins.
        drive(2'b00, 8'h01, 8'h01, 8'hFF, 1'b0); tick();
        checks++; if (q0 !== 8'h0E) begin fails++; $display("FAIL sr_forbid_p0_b got %h exp 0e", q0); end
        checks++; if (q1 !== 8'h0F) begin fails++; $display("FAIL sr_forbid_p1_b got %h exp 0f", q1); end
        checks++; if (q2 !== 8'h0E) begin fails++; $display("FAIL sr_forbid_p2_b got %h exp 0e", q2); end
        drive(2'b00, 8'h00, 8'h00, 8'hFF, 1'b1); tick();
        checks++; if (viol0 !== 8'h00 || viol_any0 !== 1'b0) begin
            fails++; $display("FAIL sr_clear got %h/%b exp 00/0", viol0, viol_any0);
        end
    endtask

    task automatic test_jk_toggle();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'hFF; exp_q[1] = 8'h00; exp_q[2] = 8'hFF;
        drive(2'b00, 8'h00, 8'hFF, 8'hFF, 1'b0); tick();
        checks++; if (q0 !== 8'h00) begin fails++; $display("FAIL jk_prep got %h exp 00", q0); end
        drive(2'b01, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (q0 !== exp_q[k] || viol0 !== 8'h00) begin
                fails++; $display("FAIL jk_toggle_%0d got %h/%h exp %h/00", k, q0, viol0, exp_q[k]);
            end
        end
    endtask

    task automatic test_d_t_enable();
        drive(2'b10, 8'h3C, 8'h00, 8'h0F, 1'b0); tick();
        checks++; if (q0 !== 8'hFC) begin fails++; $display("FAIL d_enable got %h exp fc", q0); end
        drive(2'b11, 8'hFF, 8'h00, 8'hFF, 1'b0); tick();
        checks++; if (q0 !== 8'h03) begin fails++; $display("FAIL t_toggle_a got %h exp 03", q0); end
        tick();
        checks++; if (q0 !== 8'hFC) begin fails++; $display("FAIL t_toggle_b got %h exp fc", q0); end
        drive(2'b11, 8'h00, 8'hFF, 8'hFF, 1'b0); tick();
        checks++; if (q0 !== 8'hFC) begin fails++; $display("FAIL t_hold got %h exp fc", q0); end
        // Disabled channels neither change nor record violations.
        drive(2'b00, 8'hFF, 8'hFF, 8'h00, 1'b0); tick();
        checks++; if (q0 !== 8'hFC || viol0 !== 8'h00 || viol_any0 !== 1'b0) begin
            fails++; $display("FAIL disabled_sr got %h/%h/%b exp fc/00/0", q0, viol0, viol_any0);
        end
    endtask

    task automatic test_clear_race();
        drive(2'b00, 8'h01, 8'h01, 8'hFF, 1'b0); tick();
        checks++; if (viol0 !== 8'h01) begin fails++; $display("FAIL race_prep got %h exp 01", viol0); end
        drive(2'b00, 8'h02, 8'h02, 8'hFF, 1'b1); tick();
        checks++; if (viol0 !== 8'h02 || viol_any0 !== 1'b1) begin
            fails++; $display("FAIL race_viol got %h/%b exp 02/1", viol0, viol_any0);
        end
        drive(2'b00, 8'h00, 8'h00, 8'hFF, 1'b1); tick();
        checks++; if (viol0 !== 8'h00 || viol_any0 !== 1'b0) begin
            fails++; $display("FAIL race_clear got %h/%b exp 00/0", viol0, viol_any0);
        end
        checks++; if (q0 !== 8'hFC) begin fails++; $display("FAIL race_q got %h exp fc", q0); end
    endtask

`ifdef SR_VIOL_CNT_EN
    task automatic test_viol_cnt();
        logic [3:0] exp_cnt [5];
        exp_cnt[0] = 4'd8; exp_cnt[1] = 4'd15; exp_cnt[2] = 4'd15;
        exp_cnt[3] = 4'd15; exp_cnt[4] = 4'd15;
        drive(2'b00, 8'h00, 8'h00, 8'hFF, 1'b1); tick();
        checks++; if (cnt0 !== 4'd0) begin fails++; $display("FAIL cnt_start got %0d exp 0", cnt0); end
        drive(2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (cnt0 !== exp_cnt[k]) begin
                fails++; $display("FAIL cnt_sat_%0d got %0d exp %0d", k, cnt0, exp_cnt[k]);
            end
        end
        drive(2'b00, 8'h03, 8'h03, 8'hFF, 1'b1); tick();
        checks++; if (cnt0 !== 4'd2) begin fails++; $display("FAIL cnt_race got %0d exp 2", cnt0); end
        drive(2'b00, 8'h00, 8'h00, 8'hFF, 1'b1); tick();
        checks++; if (cnt0 !== 4'd0) begin fails++; $display("FAIL cnt_clear got %0d exp 0", cnt0); end
    endtask
`endif

    task automatic test_mid_reset();
        drive(2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b0); tick();
        drive(2'b10, 8'h00, 8'h00, 8'hFF, 1'b0); tick();
        checks++; if (q0 !== 8'h00 || viol0 !== 8'hFF) begin
            fails++; $display("FAIL midrst_prep got %h/%h exp 00/ff", q0, viol0);
        end
        #3 rst = 1'b1;
        #1;
        checks++; if (q0 !== 8'hA5 || notq0 !== 8'h5A) begin
            fails++; $display("FAIL midrst_q got %h/%h exp a5/5a", q0, notq0);
        end
        checks++; if (viol0 !== 8'h00 || viol_any0 !== 1'b0) begin
            fails++; $display("FAIL midrst_viol got %h/%b exp 00/0", viol0, viol_any0);
        end
        tick();
        checks++; if (q0 !== 8'hA5) begin fails++; $display("FAIL midrst_held got %h exp a5", q0); end
        rst = 1'b0;
        tick();
        checks++; if (q0 !== 8'h00) begin fails++; $display("FAIL post_rst_d got %h exp 00", q0); end
    endtask

    initial begin
        test_reset();
        test_sr();
        test_jk_toggle();
        test_d_t_enable();
        test_clear_race();
`ifdef SR_VIOL_CNT_EN
        test_viol_cnt();
`endif
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
